bin_to_dec_decoder: RTL and testbench
=====================================

BIN_TO_DEC_DECODER -- requirements
Module: bin_to_dec_decoder

Interface
REQ-001 Parameter: none; decoder width is fixed at 4-bit input and 10-bit one-hot output.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 A  input  4  binary/BCD code to decode.
REQ-006 C  input  1  active-high clear/disable; sampled on the rising edge of clk.
REQ-007 B  output  10  registered one-hot decimal output; bit k set means A decoded to k.
REQ-008 err  output  1  registered flag; 1 when the sampled A is outside 0..9 and C=0.

Function
REQ-009 On each rising clk edge with rst=0, B and err SHALL load the decode of the A and C values present at that edge; latency is exactly 1 clock.
REQ-010 If C=1, B SHALL load 10'b0 and err SHALL load 0, regardless of A.
REQ-011 If C=0 and A is 0..9, B SHALL load a value with only bit A set (A=0 -> 10'b00_0000_0001, A=9 -> 10'b10_0000_0000), and err SHALL load 0.
REQ-012 If C=0 and A is 10..15, B SHALL load 10'b0 and err SHALL load 1.
REQ-013 B SHALL never have more than one bit set.
REQ-014 Outputs SHALL hold their value between clock edges; changes to A or C between edges have no effect until the next rising edge.
REQ-015 If A and C change in the same cycle, the values sampled at the edge SHALL determine the result (C has priority over A).
REQ-016 There is no other internal state; every output is a pure function of the inputs sampled at the previous edge.

Reset
REQ-017 While rst=1, B SHALL be 10'b0 and err SHALL be 0, immediately and independently of clk.
REQ-018 On rst deassertion, the first rising edge SHALL produce the normal decode of A and C per REQ-010..REQ-012.
REQ-019 If rst is asserted between edges, it SHALL clear the outputs immediately and discard the previously registered decode.

Structure
REQ-020 A shared package SHALL hold these constants:
- DEC_DIGITS = 10
- IN_W = 4
- ONEHOT_ZERO = 10'b0
- MAX_VALID = 4'd9
REQ-021 One combinational sub-module, bcd_onehot_decode, SHALL map (A, C) to a next-state one-hot value and an invalid flag.
REQ-022 The top level SHALL instantiate bcd_onehot_decode and contain only the output registers with the asynchronous reset.
REQ-023 The design SHALL use no latches and no clock gating.

Verification
REQ-024 Reset test: assert rst with A=4'd5 and C=0 -> B=0 and err=0 immediately, with no clock edge needed; release rst, clock once -> B=10'b00_0010_0000.
REQ-025 Clear test: C=1, A=4'd0, one edge -> B=0 and err=0; then C=0 with A unchanged, one edge -> B=10'b00_0000_0001.
REQ-026 Full sweep: C=0, apply A=0..15 with one edge each.
- A=0..9 -> B=1<<A, err=0, visible on the edge after A is applied.
- A=10..15 -> B=0, err=1.
REQ-027 Latency test: change A from 3 to 7 mid-cycle -> B stays 10'b00_0000_1000 until the next edge, then becomes 10'b00_1000_0000.
REQ-028 Priority test: C=1 and A=4'd12 at the same edge -> B=0 and err=0; then C=0 -> err=1 after one edge.
REQ-029 Mid-operation reset: with B=10'b10_0000_0000, assert rst asynchronously between edges -> B=0 at once.

Source files
------------

// File: rtl/bin_to_dec_decoder_pkg.sv
// Shared constants and helpers for the 4-bit to 10-way decimal decoder.
//   DEC_DIGITS  : number of one-hot output lines
//   IN_W        : width of the binary/BCD input code
//   ONEHOT_ZERO : all-lines-off output value
//   MAX_VALID   : largest code that maps to a decimal digit
package bin_to_dec_decoder_pkg;

  localparam int unsigned DEC_DIGITS = 10;
  localparam int unsigned IN_W       = 4;

  localparam logic [DEC_DIGITS-1:0] ONEHOT_ZERO = 10'b0;
  localparam logic [IN_W-1:0]       MAX_VALID   = 4'd9;

  // True when the code names a decimal digit.
  function automatic logic is_digit(input logic [IN_W-1:0] code);
    return code <= MAX_VALID;
  endfunction

endpackage

// File: rtl/bin_to_dec_decoder_if.sv
// Decoder data bus: input code, clear, one-hot result and error flag.
//   a   : code to decode          (master -> slave)
//   c   : clear/disable, high     (master -> slave)
//   b   : registered one-hot out  (slave -> master)
//   err : registered invalid flag (slave -> master)
interface bin_to_dec_decoder_if;
  import bin_to_dec_decoder_pkg::*;

  logic [IN_W-1:0]       a;
  logic                  c;
  logic [DEC_DIGITS-1:0] b;
  logic                  err;

  modport master (output a, output c, input b, input err);
  modport slave  (input a, input c, output b, output err);

endinterface

// File: rtl/bin_to_dec_decoder_bcd_onehot_decode.sv
// Combinational decode of (code, clear) into the next one-hot value and invalid flag.
//   i_a       : code to decode
//   i_c       : clear/disable; forces all-zero output and no error
//   o_onehot  : bit k set when i_a == k and not cleared
//   o_invalid : set when not cleared and i_a is above MAX_VALID
module bcd_onehot_decode
  import bin_to_dec_decoder_pkg::*;
(
  input  logic [IN_W-1:0]       i_a,
  input  logic                  i_c,
  output logic [DEC_DIGITS-1:0] o_onehot,
  output logic                  o_invalid
);

  always_comb begin
    o_onehot  = ONEHOT_ZERO;
    o_invalid = 1'b0;
    // Clear wins over any code value.
    if (!i_c) begin
      if (is_digit(i_a)) begin
        o_onehot = DEC_DIGITS'(1) << i_a;
      end else begin
        o_invalid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bin_to_dec_decoder.sv
// Registered 4-bit to 10-line decimal decoder with clear and invalid-code flag.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset; clears outputs immediately
//   io_dec : decoder bus (slave side) carrying a, c in and b, err out
module bin_to_dec_decoder
  import bin_to_dec_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  bin_to_dec_decoder_if.slave  io_dec
);

  logic [DEC_DIGITS-1:0] w_onehot;
  logic                  w_invalid;
  logic [DEC_DIGITS-1:0] r_b;
  logic                  r_err;

  bcd_onehot_decode u_decode (
    .i_a       (io_dec.a),
    .i_c       (io_dec.c),
    .o_onehot  (w_onehot),
    .o_invalid (w_invalid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b   <= ONEHOT_ZERO;
      r_err <= 1'b0;
    end else begin
      r_b   <= w_onehot;
      r_err <= w_invalid;
    end
  end

  assign io_dec.b   = r_b;
  assign io_dec.err = r_err;

endmodule

// File: tb/tb_bin_to_dec_decoder.sv
// Self-checking bench for bin_to_dec_decoder: directed scenarios plus randomized
// stimulus compared against an arithmetic reference of the decode rules.
module tb_bin_to_dec_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bin_to_dec_decoder_if dec_if ();

  bin_to_dec_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .io_dec (dec_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs, updated from the values present at each rising edge.
  int exp_b;
  int exp_err;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: digits 0..9 light line k, anything above is an error, clear forces zero.
  task automatic model(input int a, input int c);
    if (c != 0) begin
      exp_b   = 0;
      exp_err = 0;
    end else if (a < 10) begin
      exp_b   = 2 ** a;
      exp_err = 0;
    end else begin
      exp_b   = 0;
      exp_err = 1;
    end
  endtask

  task automatic check_outs(input string tag);
    check_val({tag, ".b"}, int'(dec_if.b), exp_b);
    check_val({tag, ".err"}, int'(dec_if.err), exp_err);
    check_val({tag, ".onehot"}, int'($countones(dec_if.b) <= 1), 1);
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input int a, input int c, input string tag);
    dec_if.a = 4'(a);
    dec_if.c = c[0];
    @(posedge clk);
    model(a, c);
    #1;
    check_outs(tag);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    dec_if.a = 4'd5;
    dec_if.c = 1'b0;

    // Reset takes effect with no clock edge.
    #1 rst = 1'b1;
    #1;
    exp_b = 0; exp_err = 0;
    check_outs("reset_async");
    @(posedge clk);
    #1;
    check_outs("reset_held");
    #2 rst = 1'b0;
    step(5, 0, "reset_release");
    check_val("reset_release_val", int'(dec_if.b), 32'h20);

    // Clear then release.
    step(0, 1, "clear_on");
    step(0, 0, "clear_off");
    check_val("clear_off_val", int'(dec_if.b), 1);

    // Full sweep.
    for (int i = 0; i < 16; i++) step(i, 0, $sformatf("sweep%0d", i));

    // Mid-cycle input change is not seen until the next edge.
    step(3, 0, "lat_a3");
    #2 dec_if.a = 4'd7;
    #1;
    check_val("lat_hold", int'(dec_if.b), 32'h8);
    @(posedge clk);
    model(7, 0);
    #1;
    check_outs("lat_a7");
    check_val("lat_a7_val", int'(dec_if.b), 32'h80);

    // Clear has priority over an invalid code.
    step(12, 1, "prio_clear");
    step(12, 0, "prio_err");
    check_val("prio_err_val", int'(dec_if.err), 1);

    // Asynchronous reset mid-operation discards the registered decode.
    step(9, 0, "mid_b9");
    #2 rst = 1'b1;
    #1;
    exp_b = 0; exp_err = 0;
    check_outs("mid_reset");
    #1 rst = 1'b0;
    step(9, 0, "mid_after");

    // Randomized: mid-cycle glitches on the inputs and occasional async resets.
    for (int n = 0; n < 300; n++) begin
      int a_fin;
      int c_fin;
      a_fin = int'($urandom_range(0, 15));
      c_fin = ($urandom_range(0, 3) == 0) ? 1 : 0;
      dec_if.a = 4'($urandom_range(0, 15));
      dec_if.c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        #1 rst = 1'b1;
        #1;
        exp_b = 0; exp_err = 0;
        check_outs("rnd_reset");
        #1 rst = 1'b0;
      end else begin
        #3;
      end
      step(a_fin, c_fin, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
